// File: rtl/quad_decoder.sv
// quad_decoder: x4 quadrature decoder with registered up/down count.
//
// Phase inputs a_in/b_in are asynchronous and pass through SYNC_STAGES-deep
// synchronizers. Each legal Gray-code step of {A,B} increments (A leads B)
// or decrements the count. A step that changes both phases at once sets a
// sticky error flag.
//
// Ports:
//   clk      - system clock, rising edge
//   rst      - synchronous active-high reset, highest priority
//   en       - decode enable (synchronizers and prev keep tracking when low)
//   a_in     - phase A, asynchronous
//   b_in     - phase B, asynchronous
//   clr      - synchronous count clear, wins over a simultaneous count
//   err_clr  - clears err, loses to a simultaneous illegal transition
//   q        - current count, WIDTH bits
//   dir      - direction of last valid count, 1 = up
//   step     - one-cycle strobe in the cycle q changes due to a count
//   err      - sticky illegal-transition flag
//
// Optional build macro QDEC_SATURATE_EN: q saturates at 0 and 2^WIDTH-1
// instead of wrapping. A blocked count still updates dir but gives no step.

module quad_decoder #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             clr,
    input  logic             err_clr,
    output logic [WIDTH-1:0] q,
    output logic             dir,
    output logic             step,
    output logic             err
);

    localparam int CW = $clog2(SYNC_STAGES + 1);

    typedef enum logic {
        ST_PRIME,
        ST_RUN
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [CW-1:0]          r_prime_cnt;
    logic [CW-1:0]          w_prime_cnt_next;
    logic [SYNC_STAGES-1:0] r_sync_a;
    logic [SYNC_STAGES-1:0] r_sync_b;
    logic [1:0]             r_prev;
    logic [WIDTH-1:0]       r_q;
    logic                   r_dir;
    logic                   r_step;
    logic                   r_err;

    logic [1:0]             w_s;
    logic                   w_up;
    logic                   w_down;
    logic                   w_illegal;
    logic                   w_decode;
    logic                   w_count;
    logic                   w_err_set;
    logic                   w_blocked;
    logic [WIDTH-1:0]       w_q_step;

    assign w_s = {r_sync_a[SYNC_STAGES-1], r_sync_b[SYNC_STAGES-1]};

    // Priming spans SYNC_STAGES+1 cycles so prev is loaded from pin values
    // that have actually crossed the (reset-cleared) synchronizer; otherwise
    // pins idling at 11 through reset would decode as an illegal 00->11.
    always_comb begin
        w_state_next     = r_state;
        w_prime_cnt_next = r_prime_cnt;
        unique case (r_state)
            ST_PRIME: begin
                if (r_prime_cnt == CW'(SYNC_STAGES)) begin
                    w_state_next = ST_RUN;
                end else begin
                    w_prime_cnt_next = r_prime_cnt + CW'(1);
                end
            end
            ST_RUN: begin
                w_state_next = ST_RUN;
            end
            default: begin
                w_state_next = ST_PRIME;
            end
        endcase
    end

    always_comb begin
        w_up      = 1'b0;
        w_down    = 1'b0;
        w_illegal = 1'b0;
        unique case ({r_prev, w_s})
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: w_up      = 1'b1;
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: w_down    = 1'b1;
            4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: w_illegal = 1'b1;
            default: ;
        endcase

        w_decode  = (r_state == ST_RUN) && en;
        w_count   = w_decode && (w_up || w_down);
        w_err_set = w_decode && w_illegal;
        w_q_step  = w_up ? (r_q + WIDTH'(1)) : (r_q - WIDTH'(1));
`ifdef QDEC_SATURATE_EN
        w_blocked = (w_up && (&r_q)) || (w_down && (~|r_q));
`else
        w_blocked = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_PRIME;
            r_prime_cnt <= '0;
            r_sync_a    <= '0;
            r_sync_b    <= '0;
            r_prev      <= '0;
            r_q         <= '0;
            r_dir       <= 1'b0;
            r_step      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_prime_cnt <= w_prime_cnt_next;
            r_sync_a    <= {r_sync_a[SYNC_STAGES-2:0], a_in};
            r_sync_b    <= {r_sync_b[SYNC_STAGES-2:0], b_in};
            r_prev      <= w_s;
            r_step      <= 1'b0;

            if (clr) begin
                r_q <= '0;
            end else if (w_count) begin
                r_dir <= w_up;
                if (!w_blocked) begin
                    r_q    <= w_q_step;
                    r_step <= 1'b1;
                end
            end

            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign q    = r_q;
    assign dir  = r_dir;
    assign step = r_step;
    assign err  = r_err;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed testbench for quad_decoder (WIDTH=8, SYNC_STAGES=2).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Honours QDEC_SATURATE_EN in the wrap scenario.

module tb_quad_decoder;

    localparam int WIDTH = 8;
    localparam int SYNC  = 2;
    localparam int LAT   = SYNC + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             a_in;
    logic             b_in;
    logic             clr;
    logic             err_clr;
    logic [WIDTH-1:0] q;
    logic             dir;
    logic             step;
    logic             err;

    int checks   = 0;
    int failures = 0;

    quad_decoder #(
        .WIDTH      (WIDTH),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .a_in   (a_in),
        .b_in   (b_in),
        .clr    (clr),
        .err_clr(err_clr),
        .q      (q),
        .dir    (dir),
        .step   (step),
        .err    (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pins(input logic [1:0] p);
        {a_in, b_in} = p;
    endtask

    // Drive one pin state and let it settle fully through the decoder.
    task automatic move(input logic [1:0] p);
        pins(p);
        repeat (4) tick();
    endtask

    task automatic test_reset();
        int pulses;
        rst = 1'b1; en = 1'b1; clr = 1'b0; err_clr = 1'b0;
        pins(2'b11);
        tick(); tick();
        checks++; if (q !== 8'd0)  begin failures++; $display("FAIL reset_q: got %0d expected 0", q); end
        checks++; if (dir !== 1'b0) begin failures++; $display("FAIL reset_dir: got %b expected 0", dir); end
        checks++; if (step !== 1'b0) begin failures++; $display("FAIL reset_step: got %b expected 0", step); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", err); end
        rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (step === 1'b1) pulses++;
        end
        checks++; if (pulses !== 0) begin failures++; $display("FAIL prime_step: got %0d pulses expected 0", pulses); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL prime_err: got %b expected 0", err); end
        checks++; if (q !== 8'd0)  begin failures++; $display("FAIL prime_q: got %0d expected 0", q); end
    endtask

    // Pins start at 11; 16 up edges bring them back to 11.
    task automatic test_up_count();
        logic [1:0] up_seq [4];
        int pulses;
        up_seq[0] = 2'b00; up_seq[1] = 2'b10; up_seq[2] = 2'b11; up_seq[3] = 2'b01;
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            pins(up_seq[(3 + i) % 4]);
            for (int k = 1; k <= 4; k++) begin
                tick();
                if (step === 1'b1) pulses++;
                checks++;
                if (step !== (k == LAT)) begin
                    failures++;
                    $display("FAIL up_step_timing: edge %0d cycle %0d got %b expected %b", i, k, step, (k == LAT));
                end
            end
        end
        checks++; if (q !== 8'd16) begin failures++; $display("FAIL up_q: got %0d expected 16", q); end
        checks++; if (dir !== 1'b1) begin failures++; $display("FAIL up_dir: got %b expected 1", dir); end
        checks++; if (pulses !== 16) begin failures++; $display("FAIL up_pulses: got %0d expected 16", pulses); end
    endtask

    // Pins 11 -> 01 -> 00 (two up edges), clear, then one down edge 00 -> 01.
    task automatic test_wrap();
        move(2'b01);
        move(2'b00);
        clr = 1'b1; tick(); clr = 1'b0; tick();
        checks++; if (q !== 8'd0) begin failures++; $display("FAIL wrap_clr_q: got %0d expected 0", q); end
        pins(2'b01);
        tick(); tick();
        checks++; if (step !== 1'b0) begin failures++; $display("FAIL wrap_early_step: got %b expected 0", step); end
        tick();
`ifdef QDEC_SATURATE_EN
        checks++; if (q !== 8'd0) begin failures++; $display("FAIL sat_q: got %0d expected 0", q); end
        checks++; if (step !== 1'b0) begin failures++; $display("FAIL sat_step: got %b expected 0", step); end
`else
        checks++; if (q !== 8'd255) begin failures++; $display("FAIL wrap_q: got %0d expected 255", q); end
        checks++; if (step !== 1'b1) begin failures++; $display("FAIL wrap_step: got %b expected 1", step); end
`endif
        checks++; if (dir !== 1'b0) begin failures++; $display("FAIL wrap_dir: got %b expected 0", dir); end
        tick();
        checks++; if (step !== 1'b0) begin failures++; $display("FAIL wrap_step_width: got %b expected 0", step); end
        tick();
    endtask

    // Pins 01 -> 00 (up), then illegal 00 -> 11 and 11 -> 00.
    task automatic test_illegal();
        logic [WIDTH-1:0] exp_q;
`ifdef QDEC_SATURATE_EN
        exp_q = 8'd1;
`else
        exp_q = 8'd0;
`endif
        move(2'b00);
        checks++; if (q !== exp_q) begin failures++; $display("FAIL ill_pre_q: got %0d expected %0d", q, exp_q); end
        move(2'b11);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL ill_err: got %b expected 1", err); end
        checks++; if (q !== exp_q) begin failures++; $display("FAIL ill_q: got %0d expected %0d", q, exp_q); end
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL ill_errclr: got %b expected 0", err); end
        pins(2'b00);
        tick(); tick();
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL ill_collide_err: got %b expected 1", err); end
        tick();
        checks++; if (q !== exp_q) begin failures++; $display("FAIL ill_collide_q: got %0d expected %0d", q, exp_q); end
    endtask

    // From pins 00: clear, 6 up edges then 1 down edge -> q=5, dir=0, pins 10.
    task automatic test_clear_collision();
        clr = 1'b1; tick(); clr = 1'b0;
        move(2'b10); move(2'b11); move(2'b01); move(2'b00); move(2'b10); move(2'b11);
        move(2'b10);
        checks++; if (q !== 8'd5) begin failures++; $display("FAIL clrcol_pre_q: got %0d expected 5", q); end
        checks++; if (dir !== 1'b0) begin failures++; $display("FAIL clrcol_pre_dir: got %b expected 0", dir); end
        pins(2'b11);
        tick(); tick();
        clr = 1'b1; tick(); clr = 1'b0;
        checks++; if (q !== 8'd0) begin failures++; $display("FAIL clrcol_q: got %0d expected 0", q); end
        checks++; if (step !== 1'b0) begin failures++; $display("FAIL clrcol_step: got %b expected 0", step); end
        checks++; if (dir !== 1'b0) begin failures++; $display("FAIL clrcol_dir: got %b expected 0", dir); end
        tick();
    endtask

    // Pins 11, q=0: one up edge, then 3 gated up edges, idle, one up edge.
    task automatic test_enable_gating();
        int pulses;
        move(2'b01);
        checks++; if (q !== 8'd1) begin failures++; $display("FAIL en_pre_q: got %0d expected 1", q); end
        en = 1'b0;
        pulses = 0;
        pins(2'b00); repeat (4) begin tick(); if (step === 1'b1) pulses++; end
        pins(2'b10); repeat (4) begin tick(); if (step === 1'b1) pulses++; end
        pins(2'b11); repeat (4) begin tick(); if (step === 1'b1) pulses++; end
        en = 1'b1;
        repeat (6) begin tick(); if (step === 1'b1) pulses++; end
        checks++; if (pulses !== 0) begin failures++; $display("FAIL en_gated_step: got %0d pulses expected 0", pulses); end
        checks++; if (q !== 8'd1) begin failures++; $display("FAIL en_gated_q: got %0d expected 1", q); end
        pins(2'b01);
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++;
            if (step !== (k == LAT)) begin
                failures++;
                $display("FAIL en_resume_step: cycle %0d got %b expected %b", k, step, (k == LAT));
            end
        end
        checks++; if (q !== 8'd2) begin failures++; $display("FAIL en_resume_q: got %0d expected 2", q); end
        checks++; if (dir !== 1'b1) begin failures++; $display("FAIL en_resume_dir: got %b expected 1", dir); end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; clr = 1'b0; err_clr = 1'b0;
        a_in = 1'b0; b_in = 1'b0;
        tick();
        test_reset();
        test_up_count();
        test_wrap();
        test_illegal();
        test_clear_collision();
        test_enable_gating();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
